// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and a byte-addressable
// data memory. Loads own the memory port when they are hazard-free; otherwise
// the oldest buffered store drains. Loads that touch a word still held in the
// buffer stall until the overlapping stores have drained.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_read,
    input  logic                      req_write,
    input  logic [2:0]                req_fun3,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      req_stall,
    output logic [31:0]               load_data,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [2:0]                mem_fun3,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [$clog2(DEPTH):0]    sb_count,
    output logic                      sb_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sb_empty_q, sb_empty_d;

    logic [2:0]        fifo_fun3_q  [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
    logic [31:0]       fifo_wdata_q [DEPTH];
    logic [2:0]        fifo_fun3_d  [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d  [DEPTH];
    logic [31:0]       fifo_wdata_d [DEPTH];

    logic hazard;
    logic is_load;
    logic is_store;
    logic st_legal;
    logic push;
    logic pop;

    // Address of the last byte of an access; wraps modulo the memory size.
    function automatic logic [ADDR_W-1:0] last_byte(input logic [2:0] f3,
                                                     input logic [ADDR_W-1:0] a);
        case (f3[1:0])
            2'b00:   return a;
            2'b01:   return a + ADDR_W'(1);
            default: return a + ADDR_W'(3);
        endcase
    endfunction

    // Two accesses conflict when any first/last word index of one matches the other's.
    function automatic logic words_overlap(input logic [2:0] fa, input logic [ADDR_W-1:0] aa,
                                           input logic [2:0] fb, input logic [ADDR_W-1:0] ab);
        logic [ADDR_W-1:0] la;
        logic [ADDR_W-1:0] lb;
        la = last_byte(fa, aa);
        lb = last_byte(fb, ab);
        return (aa[ADDR_W-1:2] == ab[ADDR_W-1:2]) || (aa[ADDR_W-1:2] == lb[ADDR_W-1:2]) ||
               (la[ADDR_W-1:2] == ab[ADDR_W-1:2]) || (la[ADDR_W-1:2] == lb[ADDR_W-1:2]);
    endfunction

    // Slot i is occupied when its distance from head is below the occupancy.
    function automatic logic slot_valid(input logic [PTR_W-1:0] slot,
                                        input logic [PTR_W-1:0] head,
                                        input logic [CNT_W-1:0] count);
        logic [PTR_W-1:0] off;
        off = slot - head;
        return {1'b0, off} < count;
    endfunction

    // Load hazard: any occupied entry touching a word the incoming request touches.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_valid(PTR_W'(i), head_q, count_q) &&
                words_overlap(fifo_fun3_q[i], fifo_addr_q[i], req_fun3, req_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Port arbitration, enqueue/dequeue and next-state computation.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fifo_fun3_d  = fifo_fun3_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_wdata_d = fifo_wdata_q;
        req_stall    = 1'b0;
        load_data    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_fun3     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        push         = 1'b0;
        pop          = 1'b0;

        is_load  = req_valid & req_read;
        is_store = req_valid & req_write & ~req_read;
        st_legal = ~req_fun3[2] & (req_fun3[1:0] != 2'b11);

        if (!rst) begin
            if (is_load && !hazard) begin
                mem_read  = 1'b1;
                mem_fun3  = req_fun3;
                mem_addr  = req_addr;
                load_data = mem_rdata;
            end else if (count_q != '0) begin
                mem_write = 1'b1;
                mem_fun3  = fifo_fun3_q[head_q];
                mem_addr  = fifo_addr_q[head_q];
                mem_wdata = fifo_wdata_q[head_q];
                pop       = 1'b1;
                head_d    = head_q + PTR_W'(1);
            end

            if (is_load && hazard) begin
                req_stall = 1'b1;
            end

            // Fullness is judged on the pre-edge count, so a same-cycle drain
            // does not make room for a store arriving in that cycle.
            if (is_store && st_legal) begin
                if (count_q == CNT_W'(DEPTH)) begin
                    req_stall = 1'b1;
                end else begin
                    push                 = 1'b1;
                    fifo_fun3_d[tail_q]  = req_fun3;
                    fifo_addr_d[tail_q]  = req_addr;
                    fifo_wdata_d[tail_q] = req_wdata;
                    tail_d               = tail_q + PTR_W'(1);
                end
            end

            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign sb_empty_d = (count_d == '0);

    // Pointer/occupancy state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sb_empty_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sb_empty_q <= sb_empty_d;
        end
    end

    // Entry storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        fifo_fun3_q  <= fifo_fun3_d;
        fifo_addr_q  <= fifo_addr_d;
        fifo_wdata_q <= fifo_wdata_d;
    end

    assign sb_count = count_q;
    assign sb_empty = sb_empty_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference of the pending
// stores predicts per-cycle port use; expected loads/writes are queued and a
// negedge monitor pops and compares whenever the DUT drives the memory port.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write;
    logic [2:0]  req_fun3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_stall;
    logic [31:0] load_data;
    logic        mem_read, mem_write;
    logic [2:0]  mem_fun3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  sb_count;
    logic        sb_empty;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_stall(req_stall), .load_data(load_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fun3(mem_fun3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [7:0]  a;
        logic [31:0] d;
    } acc_t;

    // Environment memory seen by the DUT, and the reference's committed memory.
    logic [7:0] dmem [256];
    logic [7:0] gold [256];

    acc_t mq[$];        // reference: pending stores in program order
    acc_t exp_ld_q[$];  // expected issued loads
    acc_t exp_wr_q[$];  // expected drained writes

    logic       exp_stall, exp_rd, exp_wr, chk_en;
    int         exp_cnt;
    int         tests = 0;
    int         fails = 0;

    function automatic int size_of(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // True when the two accesses share any 4-byte word of the wrapped address space.
    function automatic logic share_word(input acc_t x, input acc_t y);
        logic [7:0] bx, by;
        for (int i = 0; i < size_of(x.f); i++) begin
            for (int j = 0; j < size_of(y.f); j++) begin
                bx = x.a + 8'(i);
                by = y.a + 8'(j);
                if (bx[7:2] == by[7:2]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Combinational memory read and posedge write, little-endian with wrap.
    logic [7:0] rb0, rb1, rb2, rb3;
    assign rb0 = dmem[mem_addr];
    assign rb1 = dmem[mem_addr + 8'd1];
    assign rb2 = dmem[mem_addr + 8'd2];
    assign rb3 = dmem[mem_addr + 8'd3];
    assign mem_rdata = extend(mem_fun3, {rb3, rb2, rb1, rb0});

    always @(posedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < size_of(mem_fun3); k++) begin
                dmem[mem_addr + 8'(k)] <= mem_wdata[8*k +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle control checks plus scoreboard pops on port activity.
    always @(negedge clk) begin
        acc_t e;
        if (chk_en) begin
            check("req_stall", {31'b0, req_stall}, {31'b0, exp_stall});
            check("mem_read",  {31'b0, mem_read},  {31'b0, exp_rd});
            check("mem_write", {31'b0, mem_write}, {31'b0, exp_wr});
            check("sb_count",  {29'b0, sb_count},  32'(exp_cnt));
            check("sb_empty",  {31'b0, sb_empty},  {31'b0, exp_cnt == 0});
            if (mem_read) begin
                if (exp_ld_q.size() == 0) begin
                    check("ld_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_ld_q.pop_front();
                    check("ld_addr", {24'b0, mem_addr}, {24'b0, e.a});
                    check("ld_fun3", {29'b0, mem_fun3}, {29'b0, e.f});
                    check("load_data", load_data, e.d);
                end
            end else begin
                check("load_data_idle", load_data, 32'h0);
            end
            if (mem_write) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr",  {24'b0, mem_addr}, {24'b0, e.a});
                    check("wr_fun3",  {29'b0, mem_fun3}, {29'b0, e.f});
                    check("wr_wdata", mem_wdata, e.d);
                end
            end
            if (!mem_read && !mem_write) begin
                check("idle_addr", {24'b0, mem_addr}, 32'h0);
            end
        end
    end

    // Drive one request for one cycle and advance the reference by one cycle.
    task automatic cyc(input logic r, input logic v, input logic rd, input logic wr,
                       input logic [2:0] f, input logic [7:0] a, input logic [31:0] d,
                       output logic stalled);
        acc_t req, hd;
        logic haz, issue, load, store, legal;
        logic [31:0] w;
        rst = r; req_valid = v; req_read = rd; req_write = wr;
        req_fun3 = f; req_addr = a; req_wdata = d;
        req = '{f: f, a: a, d: d};
        exp_cnt   = mq.size();
        exp_stall = 1'b0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        if (r) begin
            mq.delete();
        end else begin
            load  = v & rd;
            store = v & wr & ~rd;
            legal = (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
            haz = 1'b0;
            foreach (mq[i]) if (share_word(mq[i], req)) haz = 1'b1;
            issue = load & ~haz;
            if (issue) begin
                for (int k = 0; k < 4; k++) w[8*k +: 8] = gold[a + 8'(k)];
                exp_ld_q.push_back('{f: f, a: a, d: extend(f, w)});
            end
            exp_rd    = issue;
            exp_wr    = !issue && mq.size() > 0;
            exp_stall = load & haz;
            if (store && legal) begin
                if (mq.size() == DEPTH) exp_stall = 1'b1;
                else mq.push_back(req);
            end
            if (exp_wr) begin
                hd = mq.pop_front();
                exp_wr_q.push_back(hd);
                for (int k = 0; k < size_of(hd.f); k++) gold[hd.a + 8'(k)] = hd.d[8*k +: 8];
            end
        end
        stalled = exp_stall;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic st;
        logic hv, hr, hw;
        logic [2:0] hf;
        logic [7:0] ha;
        logic [31:0] hd;
        logic [2:0] ld_f [5];
        ld_f = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        chk_en = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_fun3 = '0; req_addr = '0; req_wdata = '0;
        exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 8'($urandom);
            gold[i] = dmem[i];
        end
        @(posedge clk);
        #1;

        // Reset held with stores presented
        cyc(1, 1, 0, 1, 3'b010, 8'h10, 32'h01020304, st);
        cyc(1, 1, 0, 1, 3'b010, 8'h14, 32'h05060708, st);

        // SW then idle: enqueue, then drain
        cyc(0, 1, 0, 1, 3'b010, 8'h10, 32'h11223344, st);
        cyc(0, 0, 0, 0, 3'b000, 8'h00, 32'h0, st);
        cyc(0, 0, 0, 0, 3'b000, 8'h00, 32'h0, st);

        // SW then dependent LW: one stall cycle, then read-back
        cyc(0, 1, 0, 1, 3'b010, 8'h20, 32'hAABBCCDD, st);
        st = 1'b1;
        for (int i = 0; i < 8 && st; i++) cyc(0, 1, 1, 0, 3'b010, 8'h20, 32'h0, st);

        // SB then non-overlapping LW: load first, store drains after
        cyc(0, 1, 0, 1, 3'b000, 8'h30, 32'h000000A5, st);
        cyc(0, 1, 1, 0, 3'b010, 8'h40, 32'h0, st);
        cyc(0, 0, 0, 0, 3'b000, 8'h00, 32'h0, st);

        // Alternating stores and independent loads
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 1, 3'b010, 8'(8'h60 + 8'(4 * i)), $urandom, st);
            cyc(0, 1, 1, 0, 3'b101, 8'h02, 32'h0, st);
        end

        // SH at 0xFF wraps into word 0; LB at 0x00 must wait for it
        cyc(0, 1, 0, 1, 3'b001, 8'hFF, 32'h0000BE80, st);
        st = 1'b1;
        for (int i = 0; i < 8 && st; i++) cyc(0, 1, 1, 0, 3'b000, 8'h00, 32'h0, st);

        // Reset discards a pending store; later load sees the old contents
        cyc(0, 1, 0, 1, 3'b010, 8'h50, 32'hDEADBEEF, st);
        cyc(1, 0, 0, 0, 3'b000, 8'h00, 32'h0, st);
        cyc(0, 1, 1, 0, 3'b010, 8'h50, 32'h0, st);

        // Illegal store size is dropped silently
        cyc(0, 1, 0, 1, 3'b100, 8'h54, 32'h12345678, st);
        cyc(0, 1, 1, 0, 3'b010, 8'h54, 32'h0, st);

        // Randomized traffic; stalled requests are held stable
        st = 1'b0;
        hv = 0; hr = 0; hw = 0; hf = 0; ha = 0; hd = 0;
        for (int n = 0; n < 600; n++) begin
            int k;
            if (!st) begin
                k  = int'($urandom_range(0, 99));
                hd = $urandom;
                ha = ($urandom_range(0, 3) == 0) ? 8'(252 + $urandom_range(0, 3))
                                                 : 8'($urandom_range(0, 47));
                if (k < 20) begin
                    hv = 0; hr = 1'($urandom); hw = 1'($urandom); hf = 3'($urandom);
                end else if (k < 55) begin
                    hv = 1; hr = 1; hw = ($urandom_range(0, 3) == 0);
                    hf = ld_f[$urandom_range(0, 4)];
                end else begin
                    hv = 1; hr = 0; hw = 1;
                    hf = (k < 60) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                end
            end
            if ($urandom_range(0, 99) == 0) cyc(1, hv, hr, hw, hf, ha, hd, st);
            else cyc(0, hv, hr, hw, hf, ha, hd, st);
        end

        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 3'b000, 8'h00, 32'h0, st);
        check("ld_queue_drained", 32'(exp_ld_q.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
